// File: rtl/progmem_pkg.sv
// rtl/progmem_pkg.sv - shared state encoding and constants for the program memory loader
package progmem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READY,
    RUN,
    DONE
  } progmem_state_t;

  localparam int PROGMEM_CYCLE_BITS = 32;
  localparam logic [31:0] PROGMEM_HALT_WORD = '0;

  function automatic logic [PROGMEM_CYCLE_BITS-1:0] progmem_sat_inc(
    input logic [PROGMEM_CYCLE_BITS-1:0] value
  );
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/progmem_array.sv
// rtl/progmem_array.sv - program store, synchronous write and asynchronous read
module progmem_array #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 write_en,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [DATA_BITS-1:0] write_data,
  input  logic [ADDR_BITS-1:0] read_addr,
  output logic [DATA_BITS-1:0] read_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/program_memory_loader.sv
// rtl/program_memory_loader.sv - loads a program, serves core fetches and sequences core reset
// Optional watchdog that ends a run after WATCHDOG_CYCLES: define PROGMEM_WATCHDOG_EN.
module program_memory_loader
  import progmem_pkg::*;
#(
  parameter int DATA_BUS_DATA_BITS = 32,
  parameter int DATA_BUS_ADDR_BITS = 32,
  parameter int MEM_ADDR_BITS      = 8,
  parameter int WATCHDOG_CYCLES    = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [DATA_BUS_DATA_BITS-1:0] load_data,
  input  logic                          load_last,
  input  logic                          start,
  input  logic [DATA_BUS_ADDR_BITS-1:0] data_bus_addr,
  output logic [DATA_BUS_DATA_BITS-1:0] data_bus_data,
  input  logic                          halt,
  output logic                          core_reset,
  output logic                          done,
  output logic                          overflow,
  output logic                          timeout,
  output logic [MEM_ADDR_BITS:0]        load_count,
  output logic [PROGMEM_CYCLE_BITS-1:0] cycle_count
);

  localparam int DEPTH = 2**MEM_ADDR_BITS;
  localparam logic [MEM_ADDR_BITS:0] FULL_COUNT = (MEM_ADDR_BITS+1)'(DEPTH);
  localparam logic [MEM_ADDR_BITS:0] LAST_INDEX = FULL_COUNT - 1'b1;

  progmem_state_t state;

  logic                          idle_or_load;
  logic                          ready_or_done;
  logic                          accept;
  logic                          new_program;
  logic [MEM_ADDR_BITS-1:0]      write_addr;
  logic [DATA_BUS_DATA_BITS-1:0] read_data;
  logic                          addr_in_range;

  assign idle_or_load  = (state == IDLE) || (state == LOAD);
  assign ready_or_done = (state == READY) || (state == DONE);
  assign load_ready    = (idle_or_load || (ready_or_done && !start)) && (load_count != FULL_COUNT);
  assign accept        = load_valid && load_ready;
  // A word accepted after a finished load starts a fresh program at index 0.
  assign new_program   = ready_or_done && accept;
  assign write_addr    = new_program ? '0 : load_count[MEM_ADDR_BITS-1:0];

  progmem_array #(
    .DATA_BITS (DATA_BUS_DATA_BITS),
    .ADDR_BITS (MEM_ADDR_BITS)
  ) u_array (
    .clock      (clock),
    .write_en   (accept),
    .write_addr (write_addr),
    .write_data (load_data),
    .read_addr  (data_bus_addr[MEM_ADDR_BITS-1:0]),
    .read_data  (read_data)
  );

  // Unloaded or out-of-range fetches return the halt word so a runaway core stops.
  assign addr_in_range = data_bus_addr < DATA_BUS_ADDR_BITS'(load_count);
  assign data_bus_data = ((state == RUN) && addr_in_range)
                         ? read_data : DATA_BUS_DATA_BITS'(PROGMEM_HALT_WORD);

`ifdef PROGMEM_WATCHDOG_EN
  localparam logic [PROGMEM_CYCLE_BITS-1:0] WATCHDOG_LIMIT = PROGMEM_CYCLE_BITS'(WATCHDOG_CYCLES);
  logic timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      load_count  <= '0;
      cycle_count <= '0;
      core_reset  <= 1'b1;
      done        <= 1'b0;
      overflow    <= 1'b0;
`ifdef PROGMEM_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, LOAD: begin
          core_reset <= 1'b1;
          if (accept) begin
            load_count <= load_count + 1'b1;
            if (load_last) begin
              state <= READY;
            end else if (load_count == LAST_INDEX) begin
              state    <= READY;
              overflow <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        READY, DONE: begin
          core_reset <= 1'b1;
          if (start) begin
            state       <= RUN;
            cycle_count <= '0;
            done        <= 1'b0;
          end else if (accept) begin
            load_count <= (MEM_ADDR_BITS+1)'(1);
            overflow   <= 1'b0;
            done       <= 1'b0;
`ifdef PROGMEM_WATCHDOG_EN
            timeout_q  <= 1'b0;
`endif
            state      <= load_last ? READY : LOAD;
          end
        end
        RUN: begin
          // Release lags RUN entry by one cycle so the core's first fetch sees address 0.
          if (halt) begin
            state      <= DONE;
            done       <= 1'b1;
            core_reset <= 1'b1;
          end
`ifdef PROGMEM_WATCHDOG_EN
          else if (cycle_count == WATCHDOG_LIMIT) begin
            state      <= DONE;
            done       <= 1'b1;
            timeout_q  <= 1'b1;
            core_reset <= 1'b1;
          end
`endif
          else begin
            cycle_count <= progmem_sat_inc(cycle_count);
            core_reset  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// tb/tb_program_memory_loader.sv - random and directed checks against a behavioural loader model
module tb_program_memory_loader;

  localparam int DEPTH = 256;
  localparam int WD    = 16;
`ifdef PROGMEM_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_LOAD = 1, M_READY = 2, M_RUN = 3, M_DONE = 4;

  logic        clock;
  logic        reset;
  logic        load_valid, load_ready, load_last, start, halt;
  logic [31:0] load_data, data_bus_addr, data_bus_data;
  logic        core_reset, done, overflow, timeout;
  logic [8:0]  load_count;
  logic [31:0] cycle_count;

  program_memory_loader #(
    .DATA_BUS_DATA_BITS (32),
    .DATA_BUS_ADDR_BITS (32),
    .MEM_ADDR_BITS      (8),
    .WATCHDOG_CYCLES    (WD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_data     (load_data),
    .load_last     (load_last),
    .start         (start),
    .data_bus_addr (data_bus_addr),
    .data_bus_data (data_bus_data),
    .halt          (halt),
    .core_reset    (core_reset),
    .done          (done),
    .overflow      (overflow),
    .timeout       (timeout),
    .load_count    (load_count),
    .cycle_count   (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Minimal core: fetch at pc, decode register one cycle later, halt on the all-zero word.
  logic [31:0] pc, ir;
  logic        ir_v;
  logic        probe_en;
  logic [31:0] probe_addr;
  assign data_bus_addr = probe_en ? probe_addr : pc;
  assign halt = ir_v && (ir == 32'h0);

  always @(posedge clock) begin
    if (core_reset) begin
      pc <= 0; ir <= 0; ir_v <= 1'b0;
    end else begin
      ir <= data_bus_data; ir_v <= 1'b1; pc <= pc + 1;
    end
  end

  // Behavioural model of the loader
  int          m_mode, m_count, m_run_edges;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_cc;
  bit          m_done, m_ovf, m_to, m_acc;

  function automatic bit exp_ready();
    bool_ready: begin end
    return (m_mode == M_IDLE || m_mode == M_LOAD ||
            ((m_mode == M_READY || m_mode == M_DONE) && !start)) && (m_count < DEPTH);
  endfunction

  function automatic logic [31:0] exp_data();
    if (m_mode == M_RUN && data_bus_addr < m_count) return m_mem[data_bus_addr[7:0]];
    return 32'h0;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_count = 0; m_cc = 0; m_run_edges = 0;
      m_done = 0; m_ovf = 0; m_to = 0;
    end else begin
      m_acc = load_valid && exp_ready();
      if (m_mode == M_IDLE || m_mode == M_LOAD) begin
        if (m_acc) begin
          m_mem[m_count] = load_data;
          m_count++;
          if (load_last) m_mode = M_READY;
          else if (m_count == DEPTH) begin m_mode = M_READY; m_ovf = 1; end
          else m_mode = M_LOAD;
        end
      end else if (m_mode == M_READY || m_mode == M_DONE) begin
        if (start) begin
          m_mode = M_RUN; m_cc = 0; m_done = 0; m_run_edges = 0;
        end else if (m_acc) begin
          m_mem[0] = load_data; m_count = 1;
          m_ovf = 0; m_to = 0; m_done = 0;
          m_mode = load_last ? M_READY : M_LOAD;
        end
      end else begin
        if (halt) begin
          m_mode = M_DONE; m_done = 1;
        end else if (WD_ON && m_cc == WD) begin
          m_mode = M_DONE; m_done = 1; m_to = 1;
        end else begin
          if (m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 1;
          m_run_edges++;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en && !reset) begin
      chk("load_ready", load_ready, exp_ready());
      chk("data_bus_data", data_bus_data, exp_data());
      chk("core_reset", core_reset, !(m_mode == M_RUN && m_run_edges >= 1));
      chk("done", done, m_done);
      chk("overflow", overflow, m_ovf);
      chk("timeout", timeout, m_to);
      chk("load_count", load_count, 64'(m_count));
      chk("cycle_count", cycle_count, m_cc);
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [31:0] d, input bit last);
    bit r, got;
    got = 0;
    load_valid = 1; load_data = d; load_last = last;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock); r = load_ready;
      @(posedge clock); #1;
      if (r) got = 1;
    end
    load_valid = 0; load_last = 0;
    if (!got) chk("load_accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1;
    @(posedge clock); #1 start = 0;
  endtask

  initial begin
    reset = 0; load_valid = 0; load_data = 0; load_last = 0; start = 0;
    probe_en = 0; probe_addr = 0;
    #1 reset = 1;
    #2;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_cycle_count", cycle_count, 0);
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk_en = 1;

    send(32'h0400_0000, 0);
    send(32'h0800_0001, 0);
    send(32'h0C00_0002, 1);
    probe_en = 1; probe_addr = 1;
    @(negedge clock);
    chk("ld3_count", load_count, 3);
    chk("ld3_core_reset", core_reset, 1);
    chk("ld3_data_zero", data_bus_data, 0);
    @(posedge clock); #1 probe_en = 0;
    pulse_start();
    @(negedge clock); chk("run0_core_reset", core_reset, 1);
    @(negedge clock); chk("run1_core_reset", core_reset, 0);
    chk("run1_fetch0", data_bus_data, 32'h0400_0000);
    @(negedge clock); chk("fetch_addr1", data_bus_data, 32'h0800_0001);
    @(negedge clock);
    @(negedge clock); chk("fetch_addr3", data_bus_data, 0);
    @(negedge clock); chk("halt_seen", halt, 1);
    @(negedge clock);
    chk("halt_done", done, 1);
    chk("halt_core_reset", core_reset, 1);
    chk("halt_cycles", cycle_count, 5);

    @(posedge clock); #1 start = 1; load_valid = 1; load_data = 32'hDEAD_BEEF; load_last = 1;
    @(negedge clock); chk("prio_ready", load_ready, 0);
    @(posedge clock); #1 start = 0; load_valid = 0; load_last = 0;
    @(negedge clock);
    chk("prio_count", load_count, 3);
    chk("prio_cycles", cycle_count, 0);
    wait_done(50);
    chk("rerun_cycles", cycle_count, 5);
    pulse_start();
    @(posedge clock); #3 reset = 1;
    #1;
    chk("async_count", load_count, 0);
    chk("async_core_reset", core_reset, 1);
    @(posedge clock); #1 reset = 0;

    for (int i = 0; i < DEPTH; i++) send(32'h1000_0000 | i, 0);
    @(negedge clock);
    chk("ovf_flag", overflow, 1);
    chk("ovf_ready", load_ready, 0);
    chk("ovf_count", load_count, 256);
    @(posedge clock); #1 load_valid = 1; load_data = 32'h1234_5678;
    @(negedge clock); chk("full_ready", load_ready, 0);
    @(posedge clock); #1 load_valid = 0;
    @(negedge clock); chk("full_refuse", load_count, 256);
    @(posedge clock); #1;
    pulse_start();
    wait_done(600);
    if (WD_ON) begin
      chk("wd_timeout", timeout, 1);
      chk("wd_cycles", cycle_count, WD);
    end else begin
      chk("end_cycles", cycle_count, 258);
      chk("end_timeout", timeout, 0);
    end
    chk("end_done", done, 1);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      load_valid = ($urandom % 2) == 0;
      load_data  = ($urandom % 8 == 0) ? 32'h0 : $urandom;
      load_last  = ($urandom % 8) == 0;
      start      = ($urandom % 24) == 0;
      probe_en   = ($urandom % 4) == 0;
      case ($urandom % 3)
        0: probe_addr = $urandom % 8;
        1: probe_addr = $urandom % 300;
        default: probe_addr = $urandom;
      endcase
      if ($urandom % 700 == 0) begin
        reset = 1; #2 reset = 0;
      end
    end
    @(posedge clock); #1;
    load_valid = 0; load_last = 0; start = 0; probe_en = 0;
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
